// File: rtl/scheduler_pkg.sv
// Shared scheduler types: port/width constants, dequeue FSM states, destination field encoder.
// The destination field in tuser holds 2 bits per port; port p is flagged at bit 2*p of the field.
package scheduler_pkg;

  localparam int NUM_PORTS = 5;
  localparam int DATA_W    = 256;
  localparam int KEEP_W    = DATA_W / 8;
  localparam int TUSER_W   = 128;
  localparam int DST_POS   = 24;
  localparam int SEL_W     = $clog2(NUM_PORTS);
  localparam int DST_W     = 2 * NUM_PORTS;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    STREAM
  } state_e;

  function automatic logic [DST_W-1:0] dst_onehot(input logic [SEL_W-1:0] port);
    dst_onehot = DST_W'(1) << (2 * port);
  endfunction

endpackage

// File: rtl/dequeue_agent_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or above ptr_i, with wrap.
// No state; the caller owns and advances the pointer.
module rr_arbiter
  import scheduler_pkg::*;
#(
  parameter int N = NUM_PORTS,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] gnt_idx_o,
  output logic         gnt_vld_o
);

  logic [W-1:0] idx;

  // Scan from farthest to nearest offset so the requester closest to ptr_i wins.
  always_comb begin
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    idx       = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = W'((int'(ptr_i) + i) % N);
      if (req_i[idx]) begin
        gnt_idx_o = idx;
        gnt_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dequeue_agent.sv
// Dequeue agent: round-robin egress port pick, PIFO pop, then one whole packet streamed with tuser dest rewritten.
// Optional per-port packet counters on stat_pkt_cnt when DEQ_AGENT_STATS_EN is defined.
module dequeue_agent
  import scheduler_pkg::*;
(
  input  logic                 axis_aclk,
  input  logic                 axis_reset,
  input  logic [NUM_PORTS-1:0] s_axis_pifo_empty,
  input  logic [NUM_PORTS-1:0] s_axis_buffer_empty,
  input  logic [DATA_W-1:0]    s_axis_buffer_tdata,
  input  logic [KEEP_W-1:0]    s_axis_buffer_tkeep,
  input  logic [TUSER_W-1:0]   s_axis_buffer_tuser,
  input  logic                 s_axis_buffer_tlast,
  input  logic [NUM_PORTS-1:0] s_axis_port_pause,
  output logic [NUM_PORTS-1:0] m_axis_ctl_pifo_out_en,
  output logic [NUM_PORTS-1:0] m_axis_ctl_buffer_rd_en,
  output logic [SEL_W-1:0]     m_axis_ctl_buffer_sel,
  output logic [DATA_W-1:0]    m_axis_tdata,
  output logic [KEEP_W-1:0]    m_axis_tkeep,
  output logic [TUSER_W-1:0]   m_axis_tuser,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready
`ifdef DEQ_AGENT_STATS_EN
  ,
  output logic [32*NUM_PORTS-1:0] stat_pkt_cnt
`endif
);

  state_e               state_q;
  logic [SEL_W-1:0]     sel_q;
  logic [SEL_W-1:0]     rr_q;
  logic [NUM_PORTS-1:0] pifo_en_q;

  logic [NUM_PORTS-1:0] eligible;
  logic [SEL_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic                 streaming;
  logic                 beat_vld;
  logic                 beat_acc;
  logic                 pkt_done;

  assign eligible  = ~s_axis_pifo_empty & ~s_axis_port_pause;
  assign streaming = (state_q == STREAM);
  assign beat_vld  = streaming & ~s_axis_buffer_empty[sel_q];
  assign beat_acc  = beat_vld & m_axis_tready;
  assign pkt_done  = beat_acc & s_axis_buffer_tlast;

  rr_arbiter #(.N(NUM_PORTS), .W(SEL_W)) u_arb (
    .req_i     (eligible),
    .ptr_i     (rr_q),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      rr_q      <= '0;
      pifo_en_q <= '0;
    end else begin
      pifo_en_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            sel_q     <= gnt_idx;
            pifo_en_q <= NUM_PORTS'(1) << gnt_idx;
            state_q   <= POP;
          end
        end
        POP: state_q <= STREAM;
        STREAM: begin
          if (pkt_done) begin
            rr_q    <= (sel_q == SEL_W'(NUM_PORTS - 1)) ? '0 : sel_q + SEL_W'(1);
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_ctl_pifo_out_en = pifo_en_q;
  assign m_axis_ctl_buffer_sel  = sel_q;

  // Data path is a gated pass-through so every output reads zero outside STREAM.
  always_comb begin
    m_axis_tvalid           = beat_vld;
    m_axis_tdata            = '0;
    m_axis_tkeep            = '0;
    m_axis_tlast            = 1'b0;
    m_axis_tuser            = '0;
    m_axis_ctl_buffer_rd_en = beat_acc ? (NUM_PORTS'(1) << sel_q) : '0;
    if (streaming) begin
      m_axis_tdata                   = s_axis_buffer_tdata;
      m_axis_tkeep                   = s_axis_buffer_tkeep;
      m_axis_tlast                   = s_axis_buffer_tlast;
      m_axis_tuser                   = s_axis_buffer_tuser;
      m_axis_tuser[DST_POS +: DST_W] = dst_onehot(sel_q);
    end
  end

`ifdef DEQ_AGENT_STATS_EN
  logic [31:0] cnt_q [NUM_PORTS];

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
    end else if (pkt_done) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + 32'd1;
    end
  end

  always_comb begin
    stat_pkt_cnt = '0;
    for (int p = 0; p < NUM_PORTS; p++) stat_pkt_cnt[32*p +: 32] = cnt_q[p];
  end
`endif

endmodule

// File: tb/tb_dequeue_agent.sv
// Directed bench for dequeue_agent: arbitration order, pop/stream handshake, backpressure, reset.
// Stats counters are checked as well when DEQ_AGENT_STATS_EN is defined.
module tb_dequeue_agent;
  import scheduler_pkg::*;

  logic                 axis_aclk = 1'b0;
  logic                 axis_reset;
  logic [NUM_PORTS-1:0] pifo_empty;
  logic [NUM_PORTS-1:0] buf_empty;
  logic [DATA_W-1:0]    buf_tdata;
  logic [KEEP_W-1:0]    buf_tkeep;
  logic [TUSER_W-1:0]   buf_tuser;
  logic                 buf_tlast;
  logic [NUM_PORTS-1:0] pause;
  logic [NUM_PORTS-1:0] pifo_out_en;
  logic [NUM_PORTS-1:0] rd_en;
  logic [SEL_W-1:0]     sel;
  logic [DATA_W-1:0]    tdata;
  logic [KEEP_W-1:0]    tkeep;
  logic [TUSER_W-1:0]   tuser;
  logic                 tvalid;
  logic                 tlast;
  logic                 tready;
`ifdef DEQ_AGENT_STATS_EN
  logic [32*NUM_PORTS-1:0] stat_pkt_cnt;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  always #5 axis_aclk = ~axis_aclk;

  dequeue_agent dut (
    .axis_aclk              (axis_aclk),
    .axis_reset             (axis_reset),
    .s_axis_pifo_empty      (pifo_empty),
    .s_axis_buffer_empty    (buf_empty),
    .s_axis_buffer_tdata    (buf_tdata),
    .s_axis_buffer_tkeep    (buf_tkeep),
    .s_axis_buffer_tuser    (buf_tuser),
    .s_axis_buffer_tlast    (buf_tlast),
    .s_axis_port_pause      (pause),
    .m_axis_ctl_pifo_out_en (pifo_out_en),
    .m_axis_ctl_buffer_rd_en(rd_en),
    .m_axis_ctl_buffer_sel  (sel),
    .m_axis_tdata           (tdata),
    .m_axis_tkeep           (tkeep),
    .m_axis_tuser           (tuser),
    .m_axis_tvalid          (tvalid),
    .m_axis_tlast           (tlast),
    .m_axis_tready          (tready)
`ifdef DEQ_AGENT_STATS_EN
    ,
    .stat_pkt_cnt           (stat_pkt_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge axis_aclk);
  endtask

  // One single-beat packet on port p; entered at a negedge in IDLE with p winning arbitration.
  task automatic pkt1(input int p, input logic [255:0] d);
    logic [255:0] exp_user;
    exp_user = 256'(1) << (DST_POS + 2 * p);
    #1 chk("pkt1_idle_pifo", pifo_out_en, 0);
    nc();
    #1 chk("pkt1_pop_pifo", pifo_out_en, 1 << p);
    chk("pkt1_pop_sel", sel, p);
    chk("pkt1_pop_rd", rd_en, 0);
    pifo_empty[p] = 1'b1;
    nc();
    buf_empty[p] = 1'b0;
    buf_tdata = d;
    buf_tlast = 1'b1;
    buf_tuser = '0;
    tready    = 1'b1;
    #1 chk("pkt1_tvalid", tvalid, 1);
    chk("pkt1_rd", rd_en, 1 << p);
    chk("pkt1_pifo_off", pifo_out_en, 0);
    chk("pkt1_tuser", tuser, exp_user);
    chk("pkt1_tdata", tdata, d);
    nc();
    buf_empty = '1;
    buf_tlast = 1'b0;
  endtask

  initial begin
    logic [TUSER_W-1:0] eu;
    logic [4:0] rdy_pat;
    int beat;
    int npulse;

    axis_reset = 1'b1;
    pifo_empty = '1;
    buf_empty  = '1;
    buf_tdata  = '0;
    buf_tkeep  = '0;
    buf_tuser  = '0;
    buf_tlast  = 1'b0;
    pause      = '0;
    tready     = 1'b0;
    nc();
    nc();
    #1 chk("rst_pifo", pifo_out_en, 0);
    chk("rst_rd", rd_en, 0);
    chk("rst_sel", sel, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tuser", tuser, 0);
    axis_reset = 1'b0;
    nc();

    // Port 0, 2-beat packet, tuser all ones so the field clearing is visible.
    pifo_empty = 5'b11110;
    buf_empty  = 5'b11110;
    buf_tdata  = 256'hA0A0_0001;
    buf_tkeep  = '1;
    buf_tuser  = '1;
    tready     = 1'b1;
    #1 chk("t1_idle_tvalid", tvalid, 0);
    chk("t1_idle_pifo", pifo_out_en, 0);
    nc();
    #1 chk("t1_pop_pifo", pifo_out_en, 5'b00001);
    chk("t1_pop_rd", rd_en, 0);
    chk("t1_pop_tvalid", tvalid, 0);
    pifo_empty = '1;
    nc();
    eu = '1;
    eu[DST_POS +: 2*NUM_PORTS] = 10'b00_0000_0001;
    #1 chk("t1_b0_tvalid", tvalid, 1);
    chk("t1_b0_tdata", tdata, 256'hA0A0_0001);
    chk("t1_b0_tkeep", tkeep, 32'hFFFF_FFFF);
    chk("t1_b0_tuser", tuser, eu);
    chk("t1_b0_rd", rd_en, 5'b00001);
    chk("t1_b0_tlast", tlast, 0);
    chk("t1_b0_pifo", pifo_out_en, 0);
    nc();
    buf_tdata = 256'hA0A0_0002;
    buf_tlast = 1'b1;
    #1 chk("t1_b1_tdata", tdata, 256'hA0A0_0002);
    chk("t1_b1_tlast", tlast, 1);
    chk("t1_b1_rd", rd_en, 5'b00001);
    nc();
    buf_empty = '1;
    buf_tlast = 1'b0;
    #1 chk("t1_back_idle_tvalid", tvalid, 0);
    chk("t1_back_idle_rd", rd_en, 0);
    nc();

    // Ports 1,2,3 eligible: served in order 1,2,3.
    pifo_empty = 5'b10001;
    pkt1(1, 256'hB1);
    pkt1(2, 256'hB2);
    pkt1(3, 256'hB3);

    // Pointer now at 4: with ports 0 and 4 eligible, 4 goes first, then wrap to 0.
    pifo_empty = 5'b01110;
    pkt1(4, 256'hC4);
    pkt1(0, 256'hC0);

    // Port 1 paused, port 4 eligible: only 4 served; release pause, then 1.
    pifo_empty = 5'b01101;
    pause      = 5'b00010;
    pkt1(4, 256'hD4);
    for (int i = 0; i < 2; i++) begin
      #1 chk("t5_paused_pifo", pifo_out_en, 0);
      nc();
    end
    pause = '0;
    pkt1(1, 256'hD1);

    // Port 2 with its buffer empty for 4 cycles after POP.
    pifo_empty = 5'b11011;
    nc();
    #1 chk("t4_pop_pifo", pifo_out_en, 5'b00100);
    pifo_empty = '1;
    nc();
    for (int i = 0; i < 4; i++) begin
      #1 chk("t4_wait_tvalid", tvalid, 0);
      chk("t4_wait_rd", rd_en, 0);
      nc();
    end
    buf_empty[2] = 1'b0;
    buf_tdata    = 256'hE2;
    buf_tlast    = 1'b1;
    #1 chk("t4_tvalid", tvalid, 1);
    chk("t4_rd", rd_en, 5'b00100);
    nc();
    buf_empty = '1;
    buf_tlast = 1'b0;

    // Port 3, 3-beat packet with tready 1,0,1,0,1.
    pifo_empty = 5'b10111;
    nc();
    #1 chk("t3_pop_pifo", pifo_out_en, 5'b01000);
    pifo_empty = '1;
    nc();
    rdy_pat = 5'b10101;
    beat    = 0;
    npulse  = 0;
    for (int s = 0; s < 5; s++) begin
      buf_empty[3] = 1'b0;
      buf_tdata    = 256'hF30 + 256'(beat);
      buf_tlast    = (beat == 2);
      tready       = rdy_pat[s];
      #1 chk("t3_tdata", tdata, 256'hF30 + 256'(beat));
      chk("t3_tvalid", tvalid, 1);
      chk("t3_rd", rd_en, rdy_pat[s] ? 5'b01000 : 5'b00000);
      chk("t3_tlast", tlast, beat == 2);
      if (rd_en == 5'b01000) npulse++;
      nc();
      if (rdy_pat[s]) beat++;
    end
    buf_empty = '1;
    buf_tlast = 1'b0;
    tready    = 1'b1;
    #1 chk("t3_rd_pulses", npulse, 3);
    chk("t3_idle_tvalid", tvalid, 0);
`ifdef DEQ_AGENT_STATS_EN
    chk("stats_all_two", stat_pkt_cnt, {5{32'd2}});
`endif
    nc();

    // Reset during the 2nd beat of a 3-beat packet on port 4.
    pifo_empty = 5'b01111;
    nc();
    #1 chk("t6_pop_pifo", pifo_out_en, 5'b10000);
    pifo_empty = '1;
    nc();
    buf_empty[4] = 1'b0;
    buf_tdata    = 256'h60;
    buf_tkeep    = '1;
    buf_tlast    = 1'b0;
    #1 chk("t6_b0_rd", rd_en, 5'b10000);
    nc();
    buf_tdata  = 256'h61;
    axis_reset = 1'b1;
    nc();
    #1 chk("t6_rst_tvalid", tvalid, 0);
    chk("t6_rst_rd", rd_en, 0);
    chk("t6_rst_pifo", pifo_out_en, 0);
    chk("t6_rst_sel", sel, 0);
    chk("t6_rst_tdata", tdata, 0);
    chk("t6_rst_tkeep", tkeep, 0);
    chk("t6_rst_tuser", tuser, 0);
    chk("t6_rst_tlast", tlast, 0);
`ifdef DEQ_AGENT_STATS_EN
    chk("t6_rst_stats", stat_pkt_cnt, 0);
`endif
    axis_reset = 1'b0;
    buf_empty  = '1;
    nc();

    // Pointer back at 0 after reset: ports 0 and 4 eligible, 0 wins.
    pifo_empty = 5'b01110;
    pkt1(0, 256'h70);
    pifo_empty = '1;
    nc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/dequeue_agent.md
Name: dequeue_agent

Overview:
- Dequeue-side counterpart of the enqueue agent.
- Selects one egress port at a time by round-robin among ports whose PIFO holds an entry. Pops that PIFO entry, then streams one whole packet from that port's FWFT packet buffer onto the egress AXI-Stream, stamping the one-hot destination bit into tuser.
- Sits between the per-port PIFO/buffer pair and the output queues / MAC arbiter.

Parameters:
- NUM_PORTS, 5, number of egress ports (4 physical plus DMA).
- DATA_W, 256, AXIS data width.
- TUSER_W, 128, SUME metadata width.
- DST_POS, 24, bit position of port 0 destination bit in tuser. Port p uses DST_POS+2*p.

Ports:
- axis_aclk  in  1  clock
- axis_reset  in  1  reset
- s_axis_pifo_empty  in  NUM_PORTS  per-port PIFO empty flag
- s_axis_buffer_empty  in  NUM_PORTS  per-port packet buffer empty flag (FWFT)
- s_axis_buffer_tdata  in  DATA_W  head word of the buffer addressed by m_axis_ctl_buffer_sel (external mux)
- s_axis_buffer_tkeep  in  DATA_W/8  head word keep
- s_axis_buffer_tuser  in  TUSER_W  head word metadata
- s_axis_buffer_tlast  in  1  head word last flag
- s_axis_port_pause  in  NUM_PORTS  1 = port excluded from arbitration
- m_axis_ctl_pifo_out_en  out  NUM_PORTS  one-cycle pop strobe to a PIFO
- m_axis_ctl_buffer_rd_en  out  NUM_PORTS  pop strobe to a packet buffer
- m_axis_ctl_buffer_sel  out  clog2(NUM_PORTS)  index of the buffer routed to s_axis_buffer_*
- m_axis_tdata  out  DATA_W  egress data
- m_axis_tkeep  out  DATA_W/8  egress keep
- m_axis_tuser  out  TUSER_W  egress metadata with destination field rewritten
- m_axis_tvalid  out  1  egress valid
- m_axis_tlast  out  1  egress last
- m_axis_tready  in  1  egress ready

Behaviour:
- Clock and reset: single clock axis_aclk. Reset axis_reset is synchronous and active-high.
- Reset values: all outputs 0. FSM in IDLE. RR pointer = 0. sel register = 0.
- Eligibility: eligible[p] = !s_axis_pifo_empty[p] & !s_axis_port_pause[p].
- IDLE:
  - If any port is eligible, grant the first eligible port scanning from the RR pointer upward, with wrap.
  - Register sel. Go to POP.
- POP (exactly 1 cycle):
  - m_axis_ctl_pifo_out_en[sel] = 1.
  - Go to STREAM.
- STREAM:
  - m_axis_tvalid = !s_axis_buffer_empty[sel].
  - tdata, tkeep and tlast pass through combinationally.
  - tuser = s_axis_buffer_tuser with bits [DST_POS +: 2*NUM_PORTS] cleared, then bit DST_POS+2*sel set.
  - m_axis_ctl_buffer_rd_en[sel] = m_axis_tvalid & m_axis_tready. No other bits of rd_en are ever set.
  - On an accepted beat with tlast: RR pointer = (sel+1) mod NUM_PORTS, go to IDLE.
- m_axis_ctl_buffer_sel holds sel in every state.
- Latency:
  - Eligible to pifo_out_en: 2 cycles (IDLE grant, POP).
  - First egress beat can be valid the cycle after POP.
  - Minimum per-packet overhead: 2 idle cycles between packets.
- Boundaries:
  - Buffer empty in STREAM: tvalid = 0. Wait indefinitely, no timeout.
  - tready low: hold the beat, no rd_en (AXIS stability rule).
  - Pause asserted mid-packet: ignored until tlast. Pause only affects arbitration.
  - PIFO empty going high after grant: no effect, the grant stands.
  - Single eligible port: served back-to-back.
  - RR pointer wraps from NUM_PORTS-1 to 0.
  - Reset mid-packet: immediate return to IDLE with all strobes 0. The partial packet is not completed.
- The block never asserts pifo_out_en and buffer_rd_en in the same cycle.

Optional Feature:
- Macro: DEQ_AGENT_STATS_EN.
- When defined:
  - Extra output stat_pkt_cnt, width 32*NUM_PORTS, one 32-bit counter per port.
  - A counter increments on each accepted tlast beat for that port and wraps at 2^32.
  - Reset to 0.
- When undefined: the port and the counters are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package scheduler_pkg holds:
  - NUM_PORTS, DST_POS, data/keep/tuser widths.
  - FSM state enum (IDLE, POP, STREAM).
  - Function dst_onehot(port) returning the tuser destination field.
- Sub-module rr_arbiter: inputs req, pointer; outputs grant index and grant valid.
  - Purely combinational priority rotate.
  - Reused later by child-level PIFO scheduling.

Test Plan:
- Port 0 PIFO non-empty, 2-beat packet in buffer, tready=1 -> pifo_out_en=00001 for one cycle. Two beats out with tuser[24]=1 and bits 26/28/30/32=0. rd_en=00001 on both beats. Back to IDLE.
- Ports 1,2,3 all eligible from RR pointer 0, one 1-beat packet each -> grant order 1,2,3. tuser bit 26, then 28, then 30. RR pointer ends at 4.
- 3-beat packet on port 3, tready toggled 1,0,1,0,1 -> tdata held while tready=0. rd_en pulses exactly 3 times. tlast on the 3rd accepted beat.
- Port 2 granted, buffer empty for 4 cycles after POP, then data appears -> tvalid=0 and rd_en=0 for those 4 cycles, then normal streaming.
- Port 1 paused with PIFO non-empty, port 4 eligible -> only port 4 served. Pause released -> port 1 served next.
- axis_reset asserted during the 2nd beat of a 3-beat packet -> next cycle all outputs 0 and state IDLE. With DEQ_AGENT_STATS_EN defined, counters read 0.
